// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequencer.
package lfsr_pkg;

    localparam int unsigned MAX_LEN_DEF = 16;
    localparam int unsigned MIN_LEN     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        OUT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/LFSR_Fibonacci.sv
// Fibonacci LFSR: shifts left, feedback enters at bit 0, SHIFT_I+1 steps per enable.
module LFSR_Fibonacci #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                       CLK_I,
    input  logic                       EN_I,
    input  logic                       LOAD_I,
    input  logic [MAX_LEN-1:0]         SEED_I,
    input  logic [$clog2(MAX_LEN)-1:0] SHIFT_I,
    input  logic [MAX_LEN:0]           POLY_I,
    input  logic [$clog2(MAX_LEN)-1:0] LEN_I,
    output logic [MAX_LEN-1:0]         DATA_O
);

    logic [MAX_LEN-1:0] state;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] taps;
    logic [MAX_LEN-1:0] nxt;

    // POLY_I[0] is the implicit x^0 term; POLY_I[i] taps state bit i-1.
    logic poly_unused;
    assign poly_unused = POLY_I[0];

    // Next state after SHIFT_I+1 single-bit steps, confined to LEN_I bits.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(LEN_I));
        end
        taps = POLY_I[MAX_LEN:1] & len_mask;
        nxt  = state;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i <= 32'(SHIFT_I)) begin
                nxt = {nxt[MAX_LEN-2:0], ^(nxt & taps)} & len_mask;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (LOAD_I) begin
            state <= SEED_I;
        end else if (EN_I) begin
            state <= nxt;
        end
    end

    assign DATA_O = state;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer: loads the LFSR, steps it, and streams COUNT words with backpressure.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       CMD_VALID_I,
    output logic                       CMD_READY_O,
    input  logic [MAX_LEN-1:0]         CMD_SEED_I,
    input  logic [MAX_LEN:0]           CMD_POLY_I,
    input  logic [$clog2(MAX_LEN)-1:0] CMD_LEN_I,
    input  logic [$clog2(MAX_LEN)-1:0] CMD_SHIFT_I,
    input  logic [CNT_W-1:0]           CMD_COUNT_I,
    input  logic                       ABORT_I,
    output logic                       OUT_VALID_O,
    input  logic                       OUT_READY_I,
    output logic [MAX_LEN-1:0]         OUT_DATA_O,
    output logic                       OUT_LAST_O,
    output logic                       DONE_O,
    output logic                       ERR_O
);

    localparam int unsigned LW = $clog2(MAX_LEN);

    seq_state_t         state;
    logic [MAX_LEN-1:0] seed_q;
    logic [MAX_LEN:0]   poly_q;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      shift_q;
    logic [CNT_W-1:0]   rem_q;
    logic               done_q;
    logic               err_q;

    logic cmd_ok_c;
    logic accept_c;
    logic hs_c;
    logic lfsr_en_c;
    logic lfsr_load_c;

    assign cmd_ok_c    = (CMD_COUNT_I != '0) && (CMD_LEN_I >= LW'(MIN_LEN));
    assign accept_c    = CMD_VALID_I && CMD_READY_O;
    assign hs_c        = (state == OUT) && OUT_READY_I && !ABORT_I;
    assign lfsr_load_c = (state == LOAD);
    // A stalled consumer freezes the LFSR so the presented word stays put.
    assign lfsr_en_c   = (state == STEP) || (hs_c && (rem_q != CNT_W'(1)));

    assign CMD_READY_O = (state == IDLE) && !RST_I;
    assign OUT_VALID_O = (state == OUT);
    assign OUT_LAST_O  = (state == OUT) && (rem_q == CNT_W'(1));
    assign DONE_O      = done_q;
    assign ERR_O       = err_q;

    // Sequencer FSM, config registers and remaining-word counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= IDLE;
            seed_q  <= '0;
            poly_q  <= '0;
            len_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (cmd_ok_c) begin
                            seed_q  <= CMD_SEED_I;
                            poly_q  <= CMD_POLY_I;
                            len_q   <= CMD_LEN_I;
                            shift_q <= CMD_SHIFT_I;
                            rem_q   <= CMD_COUNT_I;
                            state   <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: state <= ABORT_I ? IDLE : STEP;
                STEP: state <= ABORT_I ? IDLE : OUT;
                OUT: begin
                    if (ABORT_I) begin
                        state <= IDLE;
                    end else if (OUT_READY_I) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    LFSR_Fibonacci #(
        .MAX_LEN (MAX_LEN)
    ) u_lfsr (
        .CLK_I   (CLK_I),
        .EN_I    (lfsr_en_c),
        .LOAD_I  (lfsr_load_c),
        .SEED_I  (seed_q),
        .SHIFT_I (shift_q),
        .POLY_I  (poly_q),
        .LEN_I   (len_q),
        .DATA_O  (OUT_DATA_O)
    );

endmodule
